dmem_responder: RTL and testbench

Data-side memory responder for the single-cycle RV32 core: it answers the core's load/store port (address, write strobe, size code, write data) with RAM storage, sub-word lane steering, load extension and a small MMIO region. Loads return combinationally in the same cycle, as the single-cycle datapath requires. Stores commit on the clock edge. The MMIO region holds a console TX FIFO drained by an external consumer, a free-running cycle counter and a status register.

---
 rtl/dmem_if.sv | 33 +++
 rtl/dmem_responder.sv | 211 +++++++++++++++++++++
 tb/tb_dmem_responder.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// dmem_if - data-memory bus between the RV32 core and dmem_responder.
//
// Groups the core load/store port and the console TX stream:
//   addr, memwrite, memsize, writedata  core -> responder (load/store request)
//   readdata                            responder -> core (extended load data)
//   tx_valid, tx_data                   responder -> consumer (FIFO head)
//   tx_ready                            consumer -> responder (head accepted)
//   fault                               responder -> core (sticky access fault)
//
// Modports:
//   master - the core / test driver side
//   slave  - the dmem_responder side
interface dmem_if;
    logic [31:0] addr;
    logic        memwrite;
    logic [2:0]  memsize;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        fault;

    modport master (
        output addr, memwrite, memsize, writedata, tx_ready,
        input  readdata, tx_valid, tx_data, fault
    );

    modport slave (
        input  addr, memwrite, memsize, writedata, tx_ready,
        output readdata, tx_valid, tx_data, fault
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder - data-side memory responder for the single-cycle RV32 core.
//
// Answers the core's load/store port with word RAM, byte/half lane steering,
// load sign/zero extension and an optional MMIO window. Loads are combinational;
// stores, FIFO pushes/pops and the cycle counter update on the rising clock edge.
//
// Parameters:
//   MEM_WORDS   RAM depth in 32-bit words (power of two)
//   FIFO_DEPTH  console TX FIFO entries (power of two, >= 2)
//   MMIO_BASE   base of the 16-byte MMIO window (addr[31:4] match)
//
// Ports:
//   clk    sole clock, rising edge
//   reset  synchronous, active-high
//   bus    dmem_if.slave: addr/memwrite/memsize/writedata in, readdata out,
//          tx_valid/tx_data out, tx_ready in, fault out
//
// Build option:
//   DMEM_MMIO_EN  when defined, builds the MMIO window (TXDATA, STATUS, CYCLE),
//                 the TX FIFO and the cycle counter. When undefined, MMIO
//                 addresses are ordinary (aliased) RAM and tx_valid/tx_data are 0.
module dmem_responder #(
    parameter int unsigned MEM_WORDS  = 1024,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic  clk,
    input  logic  reset,
    dmem_if.slave bus
);
    localparam int unsigned AW = $clog2(MEM_WORDS);

    logic [31:0]   mem [MEM_WORDS];
    logic [AW-1:0] idx;
    logic [31:0]   word;
    logic          is_b;
    logic          is_h;
    logic          is_w;
    logic          size_illegal;
    logic          misalign;
    logic          access_ok;
    logic          is_mmio;
    logic          ram_we;
    logic          fault_q;
    logic [3:0]    be;
    logic [31:0]   wlanes;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   ram_rd;
    logic [31:0]   mmio_rd;

    assign idx  = bus.addr[2 +: AW];
    assign word = mem[idx];

    always_comb begin
        size_illegal = 1'b0;
        case (bus.memsize)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: size_illegal = 1'b0;
            default:                                 size_illegal = 1'b1;
        endcase
    end

    assign is_b = (bus.memsize[1:0] == 2'b00);
    assign is_h = (bus.memsize[1:0] == 2'b01);
    assign is_w = (bus.memsize == 3'b010);

    // MMIO registers only accept aligned word accesses; anything narrower there
    // is classed as misaligned so it is blocked and flagged like RAM misalignment.
    assign misalign  = !size_illegal &&
                       ((is_h && bus.addr[0]) ||
                        (is_w && (bus.addr[1:0] != 2'b00)) ||
                        (is_mmio && !is_w));
    assign access_ok = !size_illegal && !misalign;

    always_comb begin
        be     = 4'b0000;
        wlanes = bus.writedata;
        if (is_w) begin
            be = 4'b1111;
        end else if (is_h) begin
            be     = bus.addr[1] ? 4'b1100 : 4'b0011;
            wlanes = {2{bus.writedata[15:0]}};
        end else if (is_b) begin
            be     = 4'b0001 << bus.addr[1:0];
            wlanes = {4{bus.writedata[7:0]}};
        end
    end

    assign byte_sel = word[{bus.addr[1:0], 3'b000} +: 8];
    assign half_sel = bus.addr[1] ? word[31:16] : word[15:0];

    // memsize[2] selects zero extension (BU/HU).
    always_comb begin
        ram_rd = '0;
        if (is_w) begin
            ram_rd = word;
        end else if (is_h) begin
            ram_rd = bus.memsize[2] ? {16'h0000, half_sel}
                                    : {{16{half_sel[15]}}, half_sel};
        end else if (is_b) begin
            ram_rd = bus.memsize[2] ? {24'h000000, byte_sel}
                                    : {{24{byte_sel[7]}}, byte_sel};
        end
    end

    assign bus.readdata = !access_ok ? 32'h0 : (is_mmio ? mmio_rd : ram_rd);

    // A store presented while reset is high is discarded.
    assign ram_we = bus.memwrite && access_ok && !is_mmio && !reset;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
                end
            end
        end
    end

    // Illegal size only faults on stores; misalignment faults loads and stores.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else if (misalign || (size_illegal && bus.memwrite)) begin
            fault_q <= 1'b1;
        end
    end

    assign bus.fault = fault_q;

`ifdef DMEM_MMIO_EN
    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic          overflow;
    logic [31:0]   cycle;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push_req;
    logic          push;
    logic [31:0]   status;

    assign is_mmio  = (bus.addr[31:4] == MMIO_BASE[31:4]);
    assign full     = (count == (PW+1)'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign pop      = !empty && bus.tx_ready;
    assign push_req = bus.memwrite && access_ok && is_mmio && (bus.addr[3:2] == 2'b00);
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push     = push_req && (!full || pop);
    assign status   = {16'h0000, 8'(count), 5'b00000, overflow, empty, full};

    always_comb begin
        mmio_rd = '0;
        case (bus.addr[3:2])
            2'b01:   mmio_rd = status;
            2'b10:   mmio_rd = cycle;
            default: mmio_rd = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            cycle    <= '0;
        end else begin
            cycle <= cycle + 32'd1;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_req && full && !pop) begin
                overflow <= 1'b1;
            end
            if (push && !pop) begin
                count <= count + (PW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (PW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            fifo_mem[wr_ptr] <= bus.writedata[7:0];
        end
    end

    // Storage is not reset, so the head byte is masked while the FIFO is empty.
    assign bus.tx_valid = !empty;
    assign bus.tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr];
`else
    logic unused_mmio;

    assign is_mmio      = 1'b0;
    assign mmio_rd      = '0;
    assign bus.tx_valid = 1'b0;
    assign bus.tx_data  = 8'h00;
    assign unused_mmio  = &{1'b0, bus.tx_ready, bus.addr[31:2+AW]};
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder - self-checking bench for dmem_responder.
//
// Load expectations and expected console bytes are queued when stimulus is
// driven and popped when the DUT presents the corresponding output. MMIO,
// FIFO and CYCLE checks are built only with DMEM_MMIO_EN; otherwise the bench
// checks MMIO aliasing onto RAM and the tied-off TX stream.
module tb_dmem_responder;
    localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;
    localparam logic [2:0]  SZ_B  = 3'b000;
    localparam logic [2:0]  SZ_H  = 3'b001;
    localparam logic [2:0]  SZ_W  = 3'b010;
    localparam logic [2:0]  SZ_BU = 3'b100;
    localparam logic [2:0]  SZ_HU = 3'b101;

    logic clk = 1'b0;
    logic reset;

    dmem_if bus ();

    dmem_responder #(
        .MEM_WORDS (1024),
        .FIFO_DEPTH(8),
        .MMIO_BASE (MMIO_BASE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          tx_count = 0;
    logic [31:0] load_q[$];
    logic [7:0]  tx_q[$];

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic we,
                                 input logic [2:0] size, input logic [31:0] wd);
        bus.addr      = a;
        bus.memwrite  = we;
        bus.memsize   = size;
        bus.writedata = wd;
    endtask

    task automatic go_idle();
        applyStimulus(32'h0, 1'b0, SZ_W, 32'h0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        go_idle();
        repeat (n) next_cycle();
        reset = 1'b0;
        tx_count = 0;
        tx_q.delete();
    endtask

    task automatic do_store(input logic [31:0] a, input logic [2:0] size,
                            input logic [31:0] wd);
        applyStimulus(a, 1'b1, size, wd);
        next_cycle();
        go_idle();
    endtask

    // The address is held across an edge so misaligned loads register a fault.
    task automatic do_load(input string tag, input logic [31:0] a,
                           input logic [2:0] size, input logic [31:0] exp);
        applyStimulus(a, 1'b0, size, 32'h0);
        load_q.push_back(exp);
        #1;
        checkOutput(tag, bus.readdata, load_q.pop_front());
        next_cycle();
        go_idle();
    endtask

    task automatic check_fault(input string tag, input logic exp);
        checkOutput(tag, {31'h0, bus.fault}, {31'h0, exp});
    endtask

    // Pushes with tx_ready low; the model keeps only what fits in 8 entries.
    task automatic store_tx(input logic [7:0] b);
        if (tx_count < 8) begin
            tx_q.push_back(b);
            tx_count++;
        end
        do_store(MMIO_BASE, SZ_W, {24'h0, b});
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 40;
        bus.tx_ready = 1'b1;
        while (tx_q.size() > 0 && budget > 0) begin
            if (bus.tx_valid) begin
                checkOutput(tag, {24'h0, bus.tx_data}, {24'h0, tx_q.pop_front()});
                tx_count--;
            end
            next_cycle();
            budget--;
        end
        checkOutput({tag, "_remaining"}, 32'(tx_q.size()), 32'd0);
        checkOutput({tag, "_valid_after"}, {31'h0, bus.tx_valid}, 32'd0);
        bus.tx_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.tx_ready = 1'b0;
        go_idle();
        do_reset(2);

        checkOutput("reset_fault", {31'h0, bus.fault}, 32'd0);
        checkOutput("reset_tx_valid", {31'h0, bus.tx_valid}, 32'd0);
        checkOutput("reset_tx_data", {24'h0, bus.tx_data}, 32'd0);

        // Load extension on one word
        do_store(32'h10, SZ_W, 32'h8000_00FF);
        do_load("lb_10", 32'h10, SZ_B, 32'hFFFF_FFFF);
        do_load("lbu_13", 32'h13, SZ_BU, 32'h0000_0080);
        do_load("lh_12", 32'h12, SZ_H, 32'hFFFF_8000);
        do_load("lhu_12", 32'h12, SZ_HU, 32'h0000_8000);
        do_load("lw_10", 32'h10, SZ_W, 32'h8000_00FF);

        // Sub-word lane steering on stores
        do_store(32'h20, SZ_W, 32'h1122_3344);
        do_store(32'h21, SZ_B, 32'h0000_00AA);
        do_load("lw_after_sb", 32'h20, SZ_W, 32'h1122_AA44);
        do_store(32'h22, SZ_H, 32'h0000_BEEF);
        do_load("lw_after_sh", 32'h20, SZ_W, 32'hBEEF_AA44);
        do_load("lb_21", 32'h21, SZ_B, 32'hFFFF_FFAA);
        check_fault("fault_clean", 1'b0);

        // Illegal size loads return 0 without faulting
        do_load("illegal_load", 32'h20, 3'b011, 32'h0);
        check_fault("fault_illegal_load", 1'b0);

        // Misalignment and suppressed stores
        do_load("lw_misaligned", 32'h21, SZ_W, 32'h0);
        check_fault("fault_misaligned", 1'b1);
        do_store(32'h23, SZ_H, 32'h0000_1111);
        do_load("lw_after_bad_sh", 32'h20, SZ_W, 32'hBEEF_AA44);
        do_store(32'h20, 3'b110, 32'h0);
        do_load("lw_after_illegal_st", 32'h20, SZ_W, 32'hBEEF_AA44);
        check_fault("fault_sticky", 1'b1);

        // Reset during a store discards it and clears the fault
        do_store(32'h40, SZ_W, 32'hCAFE_F00D);
`ifdef DMEM_MMIO_EN
        store_tx(8'h5C);
        checkOutput("tx_valid_before_flush", {31'h0, bus.tx_valid}, 32'd1);
`endif
        applyStimulus(32'h40, 1'b1, SZ_W, 32'h1234_5678);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        tx_count = 0;
        tx_q.delete();
        go_idle();
        check_fault("fault_after_reset", 1'b0);
        checkOutput("tx_valid_after_flush", {31'h0, bus.tx_valid}, 32'd0);
        do_load("lw_40_after_reset", 32'h40, SZ_W, 32'hCAFE_F00D);

`ifdef DMEM_MMIO_EN
        // CYCLE counts edges since reset released
        do_reset(1);
        repeat (5) next_cycle();
        do_load("cycle_5", MMIO_BASE + 32'h8, SZ_W, 32'd5);
        do_load("status_reset", MMIO_BASE + 32'h4, SZ_W, 32'h0000_0002);
        do_load("txdata_read", MMIO_BASE, SZ_W, 32'h0);
        do_load("reserved_read", MMIO_BASE + 32'hC, SZ_W, 32'h0);

        // Overflow: nine pushes into eight entries
        for (int i = 0; i < 9; i++) store_tx(8'h10 + 8'(i));
        do_load("status_full_ovf", MMIO_BASE + 32'h4, SZ_W, 32'h0000_0805);
        checkOutput("head_after_fill", {24'h0, bus.tx_data}, 32'h10);
        drain("drain_ovf");
        do_load("status_drained", MMIO_BASE + 32'h4, SZ_W, 32'h0000_0006);

        // Push and pop on the same edge while full
        do_reset(1);
        for (int i = 0; i < 8; i++) store_tx(8'h30 + 8'(i));
        bus.tx_ready = 1'b1;
        applyStimulus(MMIO_BASE, 1'b1, SZ_W, 32'h0000_0099);
        checkOutput("head_swap", {24'h0, bus.tx_data}, {24'h0, tx_q.pop_front()});
        tx_q.push_back(8'h99);
        next_cycle();
        go_idle();
        bus.tx_ready = 1'b0;
        do_load("status_swap", MMIO_BASE + 32'h4, SZ_W, 32'h0000_0801);
        drain("drain_swap");

        // Sub-word MMIO access is misaligned
        check_fault("fault_before_mmio_lh", 1'b0);
        do_load("mmio_lh", MMIO_BASE + 32'h4, SZ_H, 32'h0);
        check_fault("fault_mmio_lh", 1'b1);
`else
        // MMIO addresses alias onto RAM; TX stream is tied off
        do_store(MMIO_BASE + 32'h8, SZ_W, 32'h5A5A_1234);
        do_load("alias_lw_8", 32'h8, SZ_W, 32'h5A5A_1234);
        do_load("alias_lw_1008", 32'h1008, SZ_W, 32'h5A5A_1234);
        bus.tx_ready = 1'b1;
        next_cycle();
        checkOutput("tx_valid_tied", {31'h0, bus.tx_valid}, 32'd0);
        checkOutput("tx_data_tied", {24'h0, bus.tx_data}, 32'd0);
        bus.tx_ready = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
